fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequencer for the IF-stage PC register and the instruction-memory fetch handshake.
- Selects the next PC from four sources: sequential, branch, trap vector and exception return.
- Drives the PC register's write enable, so the PC advances only when a fetch has completed and the pipeline accepts it.
- Holds one pending redirect while memory is busy, and asserts flush toward IF/ID.

Parameters:
START_ADDR, 30'h0000BFF, word address of the first fetch after reset (PC[31:2] format).
TRAP_ADDR, 30'h0000C00, word address of the trap vector.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
pc  in  30  current PC[31:2] from the PC register
npc  out  30  next PC[31:2] to the PC register
pc_write  out  1  PC register write enable (PCWrite)
imem_req  out  1  fetch request to instruction memory at address pc
imem_ready  in  1  fetch complete this cycle
stall  in  1  hazard stall from ID
br_taken  in  1  branch/jump taken, resolved in EX
br_target  in  30  branch target PC[31:2]
trap  in  1  exception or interrupt request
eret  in  1  exception return
halt  in  1  stop fetching
epc  out  30  saved PC for eret
flush  out  1  kill the IF/ID instruction
fetch_count  out  32  number of pc_write pulses since reset

Behaviour:
- Reset is sampled on the rising clk edge while reset==0. On reset:
  - state<=BOOT; pending cleared; epc<=START_ADDR; fetch_count<=0.
  - Combinational outputs are 0 in BOOT; npc=START_ADDR.
- States:
  - BOOT: one cycle, imem_req=0, then go to FETCH.
  - FETCH: imem_req=1. If imem_ready==0, go to WAIT.
  - WAIT: imem_req=1 and pc unchanged until imem_ready; then return to FETCH.
  - HALTED: imem_req=0, pc_write=0, npc=pc. The only exit is reset.
- Redirect priority: trap > eret > br_taken.
  - The winning redirect target is TRAP_ADDR, epc or br_target, respectively.
- Redirect while the fetch is not completing (imem_ready==0, in FETCH or WAIT):
  - Latch the target in the pending register (tgt + prio).
  - A new request replaces a pending one only if its priority is >= the pending priority.
- Advance condition: imem_ready==1 in FETCH or WAIT.
  - If a live or pending redirect exists: pc_write=1 and npc=target, regardless of stall; pending is cleared.
  - A live redirect wins over a pending one only if its priority is strictly higher.
  - Otherwise, if stall==0: pc_write=1 and npc=pc+1 (30-bit wrap, 30'h3FFFFFFF -> 0).
  - Otherwise (stall==1): pc_write=0. Stay in FETCH with imem_req=1 and the same address, which re-fetches.
- npc when pc_write==0: equals pc.
- flush: combinational, 1 in any cycle where trap, eret or br_taken is asserted in FETCH or WAIT.
- epc: on the cycle a trap is accepted (live or latched), epc<=pc of that cycle, registered.
  - A trap that occurs in the same cycle as eret leaves epc updated by the trap.
- eret with no prior trap: jumps to the current epc (START_ADDR after reset).
- halt is sampled in FETCH/WAIT.
  - The current fetch completes, including any pending redirect.
  - The state goes to HALTED after the next pc_write, or immediately if no fetch is outstanding and imem_ready==1 with stall==1.
  - halt in BOOT is deferred to FETCH.
- fetch_count increments by 1 on every pc_write==1 cycle and wraps at 2^32.
- pc_write and npc are combinational from state, pending and the inputs. State, pending, epc and fetch_count are registered.

Test Plan:
- Reset released, imem_ready=1, stall=0, pc follows START_ADDR -> BOOT one cycle; then pc_write=1 every cycle; npc sequence 0BFF->0C00->0C01; fetch_count=3 after 3 cycles.
- Held at pc=0C10, imem_ready low 3 cycles; br_taken=1 with br_target=0x0100 in cycle 1 only; ready in cycle 4 -> flush=1 in cycle 1; pc_write=0 in cycles 1-3; cycle 4 npc=0x0100, pc_write=1.
- Pending branch 0x0100 during WAIT, then trap in the next WAIT cycle -> on ready, npc=0C00 (TRAP_ADDR) and epc=pc; with order reversed (trap then branch), npc=0C00 still.
- At pc=0C20: stall=1 with br_taken=1 (target 0x0200) and imem_ready=1 -> pc_write=1, npc=0x0200. stall=1 alone -> pc_write=0, npc=0C20, imem_req stays 1.
- Trap at pc=0C05, then eret -> npc=0C00 first, later npc=0C05. At pc=3FFFFFFF, sequential fetch -> npc=0. halt -> HALTED with pc_write=0 forever.
- reset=0 asserted mid-WAIT with a pending redirect -> next cycle BOOT, pending cleared, fetch_count=0, epc=START_ADDR; first npc after release is sequential from START_ADDR.

Source files
------------

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: picks the next PC, gates the PC register write
// and holds one redirect while instruction memory is still busy.
module fetch_ctrl #(
    parameter logic [29:0] START_ADDR = 30'h0000BFF,
    parameter logic [29:0] TRAP_ADDR  = 30'h0000C00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] pc,
    output logic [29:0] npc,
    output logic        pc_write,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [29:0] br_target,
    input  logic        trap,
    input  logic        eret,
    input  logic        halt,
    output logic [29:0] epc,
    output logic        flush,
    output logic [31:0] fetch_count,
    output logic [1:0]  o_dbg_state
);

    // Handshake: imem_req is the request valid and imem_ready completes it in
    // the same cycle; while imem_req=1 and imem_ready=0 the address (pc) is held.

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_FETCH  = 2'd1,
        S_WAIT   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [1:0] P_NONE = 2'd0;
    localparam logic [1:0] P_BR   = 2'd1;
    localparam logic [1:0] P_ERET = 2'd2;
    localparam logic [1:0] P_TRAP = 2'd3;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_pend_vld;
    logic [1:0]  r_pend_prio;
    logic [29:0] r_pend_tgt;
    logic        r_halt_req;
    logic [29:0] r_epc;
    logic [31:0] r_fetch_count;

    logic        w_active;
    logic [1:0]  w_live_prio;
    logic [29:0] w_live_tgt;
    logic [1:0]  w_pend_prio;
    logic        w_use_live;
    logic [1:0]  w_win_prio;
    logic [29:0] w_win_tgt;
    logic        w_redirect;
    logic        w_halt_req;
    logic        w_latch;

    assign w_active = (r_state == S_FETCH) || (r_state == S_WAIT);

    // Live request priority: trap > eret > branch.
    assign w_live_prio = trap     ? P_TRAP :
                         eret     ? P_ERET :
                         br_taken ? P_BR   : P_NONE;
    assign w_live_tgt  = trap ? TRAP_ADDR :
                         eret ? r_epc     : br_target;

    // A live request only overrides a held one if strictly more urgent.
    assign w_pend_prio = r_pend_vld ? r_pend_prio : P_NONE;
    assign w_use_live  = (w_live_prio > w_pend_prio);
    assign w_win_prio  = w_use_live ? w_live_prio : w_pend_prio;
    assign w_win_tgt   = w_use_live ? w_live_tgt  : r_pend_tgt;
    assign w_redirect  = (w_win_prio != P_NONE);
    assign w_halt_req  = halt || r_halt_req;

    assign w_latch = w_active && !imem_ready && (w_live_prio != P_NONE) &&
                     (w_live_prio >= w_pend_prio);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        pc_write    = 1'b0;
        npc         = pc;
        imem_req    = 1'b0;
        flush       = 1'b0;
        case (r_state)
            S_BOOT: begin
                npc         = START_ADDR;
                w_state_nxt = S_FETCH;
            end
            S_FETCH, S_WAIT: begin
                imem_req = 1'b1;
                flush    = (w_live_prio != P_NONE);
                if (imem_ready) begin
                    if (w_redirect) begin
                        pc_write = 1'b1;
                        npc      = w_win_tgt;
                    end else if (!stall) begin
                        pc_write = 1'b1;
                        npc      = pc + 30'd1;
                    end
                end
                // A stalled completed fetch leaves nothing outstanding to finish.
                if (w_halt_req && (pc_write || (imem_ready && stall))) begin
                    w_state_nxt = S_HALTED;
                end else if (imem_ready) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend_vld    <= 1'b0;
            r_pend_prio   <= P_NONE;
            r_pend_tgt    <= '0;
            r_halt_req    <= 1'b0;
            r_epc         <= START_ADDR;
            r_fetch_count <= '0;
        end else begin
            if (pc_write) begin
                r_fetch_count <= r_fetch_count + 32'd1;
                r_pend_vld    <= 1'b0;
                if (w_redirect && (w_win_prio == P_TRAP)) begin
                    r_epc <= pc;
                end
            end else if (w_latch) begin
                r_pend_vld  <= 1'b1;
                r_pend_prio <= w_live_prio;
                r_pend_tgt  <= w_live_tgt;
            end
            if (halt && (r_state != S_HALTED)) begin
                r_halt_req <= 1'b1;
            end
        end
    end

    assign epc         = r_epc;
    assign fetch_count = r_fetch_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model and a bench-side PC register.
module tb_fetch_ctrl;

    localparam logic [29:0] START = 30'h0000BFF;
    localparam logic [29:0] TRAPV = 30'h0000C00;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] pc;
    logic [29:0] npc;
    logic        pc_write;
    logic        imem_req;
    logic        imem_ready;
    logic        stall;
    logic        br_taken;
    logic [29:0] br_target;
    logic        trap;
    logic        eret;
    logic        halt;
    logic [29:0] epc;
    logic        flush;
    logic [31:0] fetch_count;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    // model state
    bit          m_boot;
    bit          m_halted;
    bit          m_halt_l;
    bit          m_pv;
    int          m_pp;
    logic [29:0] m_pt;
    logic [29:0] m_epc;
    logic [31:0] m_cnt;

    // values sampled at the last checked negedge
    logic [29:0] s_npc;
    logic        s_pw;
    logic        s_req;
    logic        s_flush;
    logic [29:0] s_epc;
    logic [31:0] s_cnt;

    always #5 clk = ~clk;

    fetch_ctrl #(.START_ADDR(START), .TRAP_ADDR(TRAPV)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .npc        (npc),
        .pc_write   (pc_write),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .trap       (trap),
        .eret       (eret),
        .halt       (halt),
        .epc        (epc),
        .flush      (flush),
        .fetch_count(fetch_count),
        .o_dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot   = 1'b1;
        m_halted = 1'b0;
        m_halt_l = 1'b0;
        m_pv     = 1'b0;
        m_pp     = 0;
        m_pt     = '0;
        m_epc    = START;
        m_cnt    = '0;
    endtask

    // One clock: predict, compare at negedge, then advance model and PC register.
    task automatic step(input bit do_check);
        int          lp;
        int          pp;
        int          wp;
        logic [29:0] lt;
        logic [29:0] wt;
        logic [29:0] e_npc;
        logic        e_pw;
        logic        e_req;
        logic        e_flush;
        @(negedge clk);
        s_npc   = npc;
        s_pw    = pc_write;
        s_req   = imem_req;
        s_flush = flush;
        s_epc   = epc;
        s_cnt   = fetch_count;
        lp = trap ? 3 : eret ? 2 : br_taken ? 1 : 0;
        lt = trap ? TRAPV : eret ? m_epc : br_target;
        pp = m_pv ? m_pp : 0;
        wp = (lp > pp) ? lp : pp;
        wt = (lp > pp) ? lt : m_pt;
        e_npc   = pc;
        e_pw    = 1'b0;
        e_req   = 1'b0;
        e_flush = 1'b0;
        if (m_boot) begin
            e_npc = START;
        end else if (!m_halted) begin
            e_req   = 1'b1;
            e_flush = (lp != 0);
            if (imem_ready) begin
                if (wp != 0) begin
                    e_pw  = 1'b1;
                    e_npc = wt;
                end else if (!stall) begin
                    e_pw  = 1'b1;
                    e_npc = pc + 30'd1;
                end
            end
        end
        if (do_check) begin
            check("npc", 32'(s_npc), 32'(e_npc));
            check("pc_write", 32'(s_pw), 32'(e_pw));
            check("imem_req", 32'(s_req), 32'(e_req));
            check("flush", 32'(s_flush), 32'(e_flush));
            check("epc", 32'(s_epc), 32'(m_epc));
            check("fetch_count", s_cnt, m_cnt);
        end
        @(posedge clk);
        #1;
        if (!reset) begin
            model_reset();
            pc = START;
        end else begin
            if (m_boot) begin
                m_boot = 1'b0;
                if (halt) m_halt_l = 1'b1;
            end else if (!m_halted) begin
                if (halt) m_halt_l = 1'b1;
                if (e_pw) begin
                    m_cnt = m_cnt + 32'd1;
                    m_pv  = 1'b0;
                    if (wp == 3) m_epc = pc;
                end else if (!imem_ready && lp != 0 && lp >= pp) begin
                    m_pv = 1'b1;
                    m_pp = lp;
                    m_pt = lt;
                end
                if (m_halt_l && (e_pw || (imem_ready && stall))) m_halted = 1'b1;
            end
            if (e_pw) pc = e_npc;
        end
    endtask

    initial begin
        reset = 1'b0; pc = START; imem_ready = 1'b1; stall = 1'b0;
        br_taken = 1'b0; br_target = '0; trap = 1'b0; eret = 1'b0; halt = 1'b0;
        model_reset();
        step(0);
        step(1);
        reset = 1'b1;

        // boot then sequential fetch
        step(1);
        check("boot_npc", 32'(s_npc), 32'(START));
        check("boot_pw", 32'(s_pw), 32'd0);
        step(1); check("seq0_npc", 32'(s_npc), 32'h0000C00);
        step(1); check("seq1_npc", 32'(s_npc), 32'h0000C01);
        step(1); check("seq2_npc", 32'(s_npc), 32'h0000C02);
        step(1); check("count3", s_cnt, 32'd3);

        // branch arrives during a slow fetch and is held until ready
        pc = 30'h0000C10; imem_ready = 1'b0; br_taken = 1'b1; br_target = 30'h100;
        step(1);
        check("wait_br_flush", 32'(s_flush), 32'd1);
        check("wait_br_pw", 32'(s_pw), 32'd0);
        br_taken = 1'b0;
        step(1); check("wait2_pw", 32'(s_pw), 32'd0);
        step(1); check("wait3_pw", 32'(s_pw), 32'd0);
        imem_ready = 1'b1;
        step(1);
        check("held_br_npc", 32'(s_npc), 32'h100);
        check("held_br_pw", 32'(s_pw), 32'd1);

        // pending branch overridden by later trap
        pc = 30'h0000D00; imem_ready = 1'b0; br_taken = 1'b1; br_target = 30'h100;
        step(1);
        br_taken = 1'b0; trap = 1'b1;
        step(1);
        trap = 1'b0; imem_ready = 1'b1;
        step(1); check("br_then_trap_npc", 32'(s_npc), 32'(TRAPV));
        step(1); check("br_then_trap_epc", 32'(s_epc), 32'h0000D00);

        // pending trap not displaced by later branch
        pc = 30'h0000D40; imem_ready = 1'b0; trap = 1'b1;
        step(1);
        trap = 1'b0; br_taken = 1'b1; br_target = 30'h100;
        step(1);
        br_taken = 1'b0; imem_ready = 1'b1;
        step(1); check("trap_then_br_npc", 32'(s_npc), 32'(TRAPV));
        step(1); check("trap_then_br_epc", 32'(s_epc), 32'h0000D40);

        // redirect beats stall; stall alone refetches
        pc = 30'h0000C20; stall = 1'b1; br_taken = 1'b1; br_target = 30'h200;
        step(1);
        check("stall_br_pw", 32'(s_pw), 32'd1);
        check("stall_br_npc", 32'(s_npc), 32'h200);
        br_taken = 1'b0; pc = 30'h0000C20;
        step(1);
        check("stall_pw", 32'(s_pw), 32'd0);
        check("stall_npc", 32'(s_npc), 32'h0000C20);
        check("stall_req", 32'(s_req), 32'd1);
        stall = 1'b0;

        // trap then eret round trip, then wrap
        pc = 30'h0000C05; trap = 1'b1;
        step(1); check("trap_npc", 32'(s_npc), 32'(TRAPV));
        trap = 1'b0;
        step(1); check("trap_epc", 32'(s_epc), 32'h0000C05);
        eret = 1'b1;
        step(1); check("eret_npc", 32'(s_npc), 32'h0000C05);
        eret = 1'b0; pc = 30'h3FFFFFFF;
        step(1); check("wrap_npc", 32'(s_npc), 32'd0);

        // halt after the next completed fetch
        halt = 1'b1;
        step(1); check("halt_last_pw", 32'(s_pw), 32'd1);
        halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            br_taken   = 1'($urandom_range(0, 1));
            trap       = 1'($urandom_range(0, 1));
            step(1);
            check("halted_pw", 32'(s_pw), 32'd0);
            check("halted_req", 32'(s_req), 32'd0);
        end
        br_taken = 1'b0; trap = 1'b0; imem_ready = 1'b1;

        // reset in WAIT with a pending redirect
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        step(1);
        pc = 30'h0000E00; trap = 1'b1;
        step(1);
        trap = 1'b0; imem_ready = 1'b0; br_taken = 1'b1; br_target = 30'h300;
        step(1);
        br_taken = 1'b0;
        step(1);
        reset = 1'b0;
        step(1);
        reset = 1'b1; imem_ready = 1'b1;
        step(1);
        check("rst_cnt", s_cnt, 32'd0);
        check("rst_epc", 32'(s_epc), 32'(START));
        check("rst_boot_pw", 32'(s_pw), 32'd0);
        step(1);
        check("rst_first_npc", 32'(s_npc), 32'(START + 30'd1));

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) != 0);
            if (m_halted && $urandom_range(0, 7) == 0) reset = 1'b0;
            imem_ready = ($urandom_range(0, 9) < 7);
            stall      = ($urandom_range(0, 3) == 0);
            br_taken   = ($urandom_range(0, 6) == 0);
            br_target  = 30'($urandom);
            trap       = ($urandom_range(0, 19) == 0);
            eret       = ($urandom_range(0, 19) == 0);
            halt       = ($urandom_range(0, 149) == 0);
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
